// File: rtl/add_result_accumulator_if.sv
// Adder-result stream in, batch result out; the upstream side (master) drives
// beats and takes results, the accumulator (slave) drives handshakes and result.
interface add_result_accumulator_if #(
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      Sum;
  logic             Cout;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] total;
  logic [3:0]       count;
  logic             ovf;

  modport master (
    output in_valid, Sum, Cout, flush, out_ready,
    input  in_ready, out_valid, total, count, ovf
  );

  modport slave (
    input  in_valid, Sum, Cout, flush, out_ready,
    output in_ready, out_valid, total, count, ovf
  );
endinterface

// File: rtl/add_result_accumulator.sv
// Sums N_OPS 17-bit {Cout,Sum} results per batch (or fewer on flush); result held
// with out_valid one cycle after the closing beat, in_ready low until it is taken.
module add_result_accumulator #(
  parameter int N_OPS = 4,
  parameter int ACC_W = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  add_result_accumulator_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum_ext;

  always_comb begin
    accept  = in_ready_q & bus.in_valid;
    operand = ACC_W'({bus.Cout, bus.Sum});
    sum_ext = {1'b0, acc_q} + {1'b0, operand};

    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = sum_ext[ACC_W-1:0];
          count_d = count_q + 4'd1;
          ovf_d   = ovf_q | sum_ext[ACC_W];
          state_d = (count_d == 4'(N_OPS) || bus.flush) ? DONE : ACCUM;
        end else if (state_q == ACCUM && bus.flush) begin
          // An empty batch has nothing to report, so flush only closes a started one.
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.total     = acc_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;
endmodule
